gc_response_rx: RTL and testbench

- Receiver for the GameCube controller single-wire open-drain protocol.
- Watches the shared data line after the query transmitter releases it.
- Times each low pulse, decodes the controller's response bits (MSB first) and checks the stop bit.
- Presents the response word with a one-cycle valid strobe, or flags an error, to the controller-state logic.

---
 rtl/gc_response_rx_if.sv | 23 ++
 rtl/gc_response_rx.sv | 175 +++++++++++++++++
 tb/tb_gc_response_rx.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gc_response_rx_if.sv
// GameCube controller response receiver bus: raw data line, arm strobe,
// and the decoded response handshake towards the controller-state logic.
interface gc_response_rx_if #(
    parameter int RESP_BITS = 64
);
    logic                 data_in;
    logic                 arm;
    logic                 busy;
    logic                 valid;
    logic                 error;
    logic [RESP_BITS-1:0] response;
    logic [6:0]           bit_count;

    modport master (
        output data_in, arm,
        input  busy, valid, error, response, bit_count
    );

    modport slave (
        input  data_in, arm,
        output busy, valid, error, response, bit_count
    );
endinterface

// File: rtl/gc_response_rx.sv
// GameCube controller single-wire response receiver (pulse-width decoder).
// Optional macro GC_RX_GLITCH_FILTER_EN adds an 8-cycle input stability filter.
module gc_response_rx #(
    parameter int CLKS_PER_US = 100,
    parameter int RESP_BITS   = 64,
    parameter int TIMEOUT_US  = 100
) (
    input  logic            clk100mhz,
    input  logic            reset,
    gc_response_rx_if.slave bus
);

    localparam int THRESH   = 2 * CLKS_PER_US;
    localparam int MAX_LOW  = 5 * CLKS_PER_US;
    localparam int MAX_HIGH = 5 * CLKS_PER_US;
    localparam int TMO      = TIMEOUT_US * CLKS_PER_US;
    localparam int CW       = $clog2(TMO + 1);

    localparam logic [CW-1:0] TMO_M1    = CW'(TMO - 1);
    localparam logic [CW-1:0] THRESH_M1 = CW'(THRESH - 1);
    localparam logic [CW-1:0] LOW_LIM   = CW'(MAX_LOW);
    localparam logic [CW-1:0] HIGH_LIM  = CW'(MAX_HIGH);
    localparam logic [6:0]    NBITS     = 7'(RESP_BITS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        LOW,
        HIGH
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic                 prev_q;
    logic                 lvl;
    logic                 fall, rise;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [RESP_BITS-1:0] shift_q, shift_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic [6:0]           bc_q, bc_d;
    logic                 valid_q, valid_d;
    logic                 error_q, error_d;
    logic                 bit_v;

    always_ff @(posedge clk100mhz or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.data_in};
        end
    end

`ifdef GC_RX_GLITCH_FILTER_EN
    logic       filt_q;
    logic [2:0] fcnt_q;

    always_ff @(posedge clk100mhz or negedge reset) begin
        if (!reset) begin
            filt_q <= 1'b1;
            fcnt_q <= 3'd0;
        end else if (sync_q[1] == filt_q) begin
            fcnt_q <= 3'd0;
        end else if (fcnt_q == 3'd7) begin
            filt_q <= sync_q[1];
            fcnt_q <= 3'd0;
        end else begin
            fcnt_q <= fcnt_q + 3'd1;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[1];
`endif

    always_ff @(posedge clk100mhz or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= lvl;
        end
    end

    assign fall    = prev_q & ~lvl;
    assign rise    = ~prev_q & lvl;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    // cnt holds low length minus one: the falling-edge cycle is not counted
    assign bit_v   = (cnt_q < THRESH_M1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        shift_d = shift_q;
        bc_d    = bc_q;
        resp_d  = resp_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.arm && !valid_q && !error_q) begin
                    shift_d = '0;
                    bc_d    = '0;
                    state_d = WAIT_FIRST;
                end
            end
            WAIT_FIRST: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = LOW;
                end else if (cnt_q == TMO_M1) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            LOW: begin
                if (rise) begin
                    cnt_d = '0;
                    if (bc_q < NBITS) begin
                        shift_d = {shift_q[RESP_BITS-2:0], bit_v};
                        bc_d    = bc_q + 7'd1;
                        state_d = HIGH;
                    end else if (bit_v) begin
                        resp_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end else if (cnt_q == LOW_LIM) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            HIGH: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = LOW;
                end else if (cnt_q == HIGH_LIM) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk100mhz or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            resp_q  <= '0;
            bc_q    <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            resp_q  <= resp_d;
            bc_q    <= bc_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.valid     = valid_q;
    assign bus.error     = error_q;
    assign bus.response  = resp_q;
    assign bus.bit_count = bc_q;

endmodule

// File: tb/tb_gc_response_rx.sv
// Self-checking bench for gc_response_rx: pulse-width frames built from
// width tables, expected words derived from the low-time rule.
module tb_gc_response_rx;

    localparam int  THR = 200;
`ifdef GC_RX_GLITCH_FILTER_EN
    localparam int  LAT = 11;
    localparam bit  GLT = 1'b1;
`else
    localparam int  LAT = 3;
    localparam bit  GLT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gc_response_rx_if #(.RESP_BITS(64)) bus ();

    gc_response_rx dut (
        .clk100mhz (clk),
        .reset     (rst_n),
        .bus       (bus)
    );

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    int          vcnt = 0, ecnt = 0, both = 0;
    longint      vcyc = 0, ecyc = 0, rise_cyc = 0, arm_cyc = 0;
    logic [6:0]  ebc;
    logic [63:0] exp_resp = 64'h0;
    int          lw[65];
    int          hw[65];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.valid) begin
                vcnt++;
                vcyc = cyc;
            end
            if (bus.error) begin
                ecnt++;
                ecyc = cyc;
                ebc  = bus.bit_count;
            end
            if (bus.valid && bus.error) both++;
        end
    end

    function automatic logic [63:0] model_word();
        logic [63:0] m = 64'h0;
        for (int i = 0; i < 64; i++) m = {m[62:0], (lw[i] < THR)};
        return m;
    endfunction

    task automatic fill(input logic [63:0] w, input bit nominal);
        for (int i = 0; i < 64; i++) begin
            if (nominal) begin
                lw[i] = w[63-i] ? 100 : 300;
                hw[i] = w[63-i] ? 300 : 100;
            end else begin
                lw[i] = w[63-i] ? int'($urandom_range(150, 60))
                                : int'($urandom_range(230, 200));
                hw[i] = int'($urandom_range(90, 60));
            end
        end
        lw[64] = 100;
        hw[64] = 0;
    endtask

    task automatic drive_frame(input int nbits, input int arm_at, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            bus.data_in = 1'b0;
            repeat (lw[i]) @(negedge clk);
            bus.data_in = 1'b1;
            if (i == 64) begin
                rise_cyc = cyc;
            end else if (i == arm_at) begin
                bus.arm = 1'b1;
                @(negedge clk);
                bus.arm = 1'b0;
                repeat (hw[i] - 1) @(negedge clk);
            end else if (glitch) begin
                repeat (30) @(negedge clk);
                bus.data_in = 1'b0;
                repeat (5) @(negedge clk);
                bus.data_in = 1'b1;
                repeat (hw[i] - 35) @(negedge clk);
            end else begin
                repeat (hw[i]) @(negedge clk);
            end
        end
    endtask

    task automatic arm_pulse();
        @(negedge clk);
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        arm_cyc = cyc;
    endtask

    task automatic wait_event(input int v0, input int e0, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            @(negedge clk);
            ok = (vcnt != v0) || (ecnt != e0);
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got b%b v%b e%b want 000", bus.busy, bus.valid, bus.error);
        end
        checks++;
        if (bus.response !== 64'h0 || bus.bit_count !== 7'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%0d want 0/0", bus.response, bus.bit_count);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_nominal();
        int v0, e0;
        bit ok;
        fill(64'h0080_8080_8080_1F1F, 1'b1);
        v0 = vcnt;
        e0 = ecnt;
        arm_pulse();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL nominal_busy got %b want 1", bus.busy);
        end
        repeat (20) @(negedge clk);
        drive_frame(65, -1, 1'b0);
        wait_event(v0, e0, 40, ok);
        checks++;
        if (!ok || vcnt != v0 + 1 || ecnt != e0) begin
            errors++;
            $display("FAIL nominal_pulse got v%0d e%0d want v%0d e%0d", vcnt - v0, ecnt - e0, 1, 0);
        end
        checks++;
        if (bus.response !== model_word()) begin
            errors++;
            $display("FAIL nominal_resp got %h want %h", bus.response, model_word());
        end
        checks++;
        if (vcyc - rise_cyc != LAT) begin
            errors++;
            $display("FAIL nominal_latency got %0d want %0d", vcyc - rise_cyc, LAT);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL nominal_busy_end got %b want 0", bus.busy);
        end
        exp_resp = model_word();
    endtask

    task automatic test_timeout();
        int v0, e0;
        bit ok;
        v0 = vcnt;
        e0 = ecnt;
        arm_pulse();
        wait_event(v0, e0, 10100, ok);
        checks++;
        if (!ok || ecnt != e0 + 1 || vcnt != v0) begin
            errors++;
            $display("FAIL timeout_pulse got e%0d v%0d want e1 v0", ecnt - e0, vcnt - v0);
        end
        checks++;
        if (ecyc - arm_cyc != 10000) begin
            errors++;
            $display("FAIL timeout_cycle got %0d want 10000", ecyc - arm_cyc);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.response !== exp_resp) begin
            errors++;
            $display("FAIL timeout_state got b%b %h want b0 %h", bus.busy, bus.response, exp_resp);
        end
    endtask

    task automatic test_bad_stop();
        int v0, e0;
        bit ok;
        fill({$urandom, $urandom}, 1'b0);
        lw[64] = 300;
        v0 = vcnt;
        e0 = ecnt;
        arm_pulse();
        repeat (20) @(negedge clk);
        drive_frame(65, -1, 1'b0);
        wait_event(v0, e0, 40, ok);
        checks++;
        if (!ok || ecnt != e0 + 1 || vcnt != v0) begin
            errors++;
            $display("FAIL badstop_pulse got e%0d v%0d want e1 v0", ecnt - e0, vcnt - v0);
        end
        checks++;
        if (bus.response !== exp_resp) begin
            errors++;
            $display("FAIL badstop_resp got %h want %h", bus.response, exp_resp);
        end
    endtask

    task automatic test_stuck_low();
        int v0, e0;
        bit ok;
        longint l0;
        fill({$urandom, $urandom}, 1'b0);
        v0 = vcnt;
        e0 = ecnt;
        arm_pulse();
        repeat (20) @(negedge clk);
        drive_frame(10, -1, 1'b0);
        bus.data_in = 1'b0;
        l0 = cyc;
        wait_event(v0, e0, 700, ok);
        checks++;
        if (!ok || ecnt != e0 + 1 || vcnt != v0) begin
            errors++;
            $display("FAIL stuck_pulse got e%0d v%0d want e1 v0", ecnt - e0, vcnt - v0);
        end
        checks++;
        if (ecyc - l0 != 504 + LAT - 3) begin
            errors++;
            $display("FAIL stuck_cycle got %0d want %0d", ecyc - l0, 504 + LAT - 3);
        end
        checks++;
        if (ebc !== 7'd10) begin
            errors++;
            $display("FAIL stuck_bitcount got %0d want 10", ebc);
        end
        repeat (100) @(negedge clk);
        bus.data_in = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int v0, e0;
        fill({$urandom, $urandom}, 1'b0);
        arm_pulse();
        repeat (20) @(negedge clk);
        drive_frame(30, -1, 1'b0);
        v0 = vcnt;
        e0 = ecnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.bit_count !== 7'd0 || bus.response !== 64'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got b%b %0d %h want 0 0 0", bus.busy, bus.bit_count, bus.response);
        end
        exp_resp = 64'h0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (vcnt != v0 || ecnt != e0) begin
            errors++;
            $display("FAIL rstmid_nopulse got v%0d e%0d want v0 e0", vcnt - v0, ecnt - e0);
        end
    endtask

    task automatic test_boundary();
        int v0, e0;
        bit ok;
        logic [63:0] m;
        fill({$urandom, $urandom}, 1'b0);
        lw[5] = 199;
        lw[6] = 200;
        hw[5] = 200;
        hw[6] = 200;
        m = model_word();
        v0 = vcnt;
        e0 = ecnt;
        arm_pulse();
        repeat (20) @(negedge clk);
        drive_frame(65, 20, GLT);
        wait_event(v0, e0, 40, ok);
        checks++;
        if (!ok || vcnt != v0 + 1 || ecnt != e0) begin
            errors++;
            $display("FAIL bound_pulse got v%0d e%0d want v1 e0", vcnt - v0, ecnt - e0);
        end
        checks++;
        if (bus.response !== m) begin
            errors++;
            $display("FAIL bound_resp got %h want %h", bus.response, m);
        end
        checks++;
        if (bus.response[58] !== 1'b1 || bus.response[57] !== 1'b0) begin
            errors++;
            $display("FAIL bound_bits got %b%b want 10", bus.response[58], bus.response[57]);
        end
        checks++;
        if (vcyc - rise_cyc != LAT) begin
            errors++;
            $display("FAIL bound_latency got %0d want %0d", vcyc - rise_cyc, LAT);
        end
        exp_resp = m;
    endtask

    task automatic test_exclusive();
        checks++;
        if (both != 0) begin
            errors++;
            $display("FAIL exclusive got %0d overlaps want 0", both);
        end
    endtask

    initial begin
        bus.data_in = 1'b1;
        bus.arm     = 1'b0;
        test_reset();
        test_nominal();
        test_timeout();
        test_bad_stop();
        test_stuck_low();
        test_reset_mid();
        test_boundary();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
